// File: rtl/cpu_pkg.sv
// cpu_pkg: decoded control bundle and architectural register constants
// shared by the pipeline stages.
package cpu_pkg;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       uses_rm;
        logic [2:0] alu_op;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/comparator_5.sv
// comparator_5: equality compare of two register specifiers.
module comparator_5 #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq
);

    always_comb eq = (a == b);

endmodule

// File: rtl/load_use_detect.sv
// load_use_detect: flags a decode instruction that reads the destination
// of a load currently in EX; XZR never creates a dependency.
module load_use_detect
    import cpu_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rm,
    output logic             hazard
);

    logic rn_eq;
    logic rm_eq;
    logic rd_zr;

    comparator_5 #(.W(REG_W)) u_cmp_rn (.a(ex_rd), .b(id_rn), .eq(rn_eq));
    comparator_5 #(.W(REG_W)) u_cmp_rm (.a(ex_rd), .b(id_rm), .eq(rm_eq));
    comparator_5 #(.W(REG_W)) u_cmp_zr (.a(ex_rd), .b(REG_W'(XZR)), .eq(rd_zr));

    always_comb hazard = ex_valid & ex_mem_read & ~rd_zr & id_valid
                       & (rn_eq | (rm_eq & id_uses_rm));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion,
// flush squashing, memory-stall freeze and a saturating bubble counter.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rn,
    input  logic [REG_W-1:0]  id_rm,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  ctrl_t             id_ctrl,
    input  logic              flush,
    input  logic              mem_hold,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rn,
    output logic [REG_W-1:0]  ex_rm,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output ctrl_t             ex_ctrl,
    output logic [15:0]       bubble_count
);

    localparam logic [REG_W-1:0] ZR = REG_W'(XZR);

    logic              ex_valid_q,  ex_valid_d;
    logic [REG_W-1:0]  ex_rn_q,     ex_rn_d;
    logic [REG_W-1:0]  ex_rm_q,     ex_rm_d;
    logic [REG_W-1:0]  ex_rd_q,     ex_rd_d;
    logic [DATA_W-1:0] ex_rdata1_q, ex_rdata1_d;
    logic [DATA_W-1:0] ex_rdata2_q, ex_rdata2_d;
    logic [DATA_W-1:0] ex_imm_q,    ex_imm_d;
    ctrl_t             ex_ctrl_q,   ex_ctrl_d;
    logic [15:0]       bubble_q,    bubble_d;
    logic              hazard;

    load_use_detect #(.REG_W(REG_W)) u_lud (
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_ctrl_q.mem_read),
        .ex_rd       (ex_rd_q),
        .id_valid    (id_valid),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_uses_rm  (id_ctrl.uses_rm),
        .hazard      (hazard)
    );

    always_comb stall_id = (mem_hold | hazard) & ~flush & ~reset;

    // A bubble leaves EX empty so the held decode instruction advances next cycle.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_rn_d     = ex_rn_q;
        ex_rm_d     = ex_rm_q;
        ex_rd_d     = ex_rd_q;
        ex_rdata1_d = ex_rdata1_q;
        ex_rdata2_d = ex_rdata2_q;
        ex_imm_d    = ex_imm_q;
        ex_ctrl_d   = ex_ctrl_q;
        bubble_d    = bubble_q;
        if (flush || (!mem_hold && hazard)) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_rd_d    = ZR;
            if (!flush && bubble_q != 16'hFFFF)
                bubble_d = bubble_q + 16'd1;
        end else if (!mem_hold) begin
            ex_valid_d  = id_valid;
            ex_rn_d     = id_rn;
            ex_rm_d     = id_rm;
            ex_rd_d     = id_rd;
            ex_rdata1_d = id_rdata1;
            ex_rdata2_d = id_rdata2;
            ex_imm_d    = id_imm;
            ex_ctrl_d   = id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q  <= 1'b0;
            ex_rn_q     <= ZR;
            ex_rm_q     <= ZR;
            ex_rd_q     <= ZR;
            ex_rdata1_q <= '0;
            ex_rdata2_q <= '0;
            ex_imm_q    <= '0;
            ex_ctrl_q   <= '0;
            bubble_q    <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rn_q     <= ex_rn_d;
            ex_rm_q     <= ex_rm_d;
            ex_rd_q     <= ex_rd_d;
            ex_rdata1_q <= ex_rdata1_d;
            ex_rdata2_q <= ex_rdata2_d;
            ex_imm_q    <= ex_imm_d;
            ex_ctrl_q   <= ex_ctrl_d;
            bubble_q    <= bubble_d;
        end
    end

    always_comb begin
        ex_valid     = ex_valid_q;
        ex_rn        = ex_rn_q;
        ex_rm        = ex_rm_q;
        ex_rd        = ex_rd_q;
        ex_rdata1    = ex_rdata1_q;
        ex_rdata2    = ex_rdata2_q;
        ex_imm       = ex_imm_q;
        ex_ctrl      = ex_ctrl_q;
        bubble_count = bubble_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors push hand-computed expectations into a
// scoreboard; a negedge monitor pops and compares against the DUT.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic [63:0] id_rdata1, id_rdata2, id_imm;
    ctrl_t       id_ctrl;
    logic        flush, mem_hold;
    logic        stall_id, ex_valid;
    logic [4:0]  ex_rn, ex_rm, ex_rd;
    logic [63:0] ex_rdata1, ex_rdata2, ex_imm;
    ctrl_t       ex_ctrl;
    logic [15:0] bubble_count;

    id_ex_stage #(.DATA_W(64), .REG_W(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .flush(flush), .mem_hold(mem_hold), .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .bubble_count(bubble_count)
    );

    localparam ctrl_t ADD = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                              alu_src: 1'b0, uses_rm: 1'b1, alu_op: 3'b010, branch: 1'b0};
    localparam ctrl_t LD  = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0, mem_to_reg: 1'b1,
                              alu_src: 1'b1, uses_rm: 1'b0, alu_op: 3'b000, branch: 1'b0};
    localparam ctrl_t Z   = '0;

    typedef struct {
        logic        stall;
        logic        valid;
        logic        data;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [63:0] d1;
        ctrl_t       ctrl;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   passes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Rdata2 and imm are driven as fixed functions of rdata1 so one expected value covers all three.
    task automatic step(input int rst, input int v, input int rn, input int rm, input int rd,
                        input int d1, input ctrl_t c, input int fl, input int mh,
                        input int es, input int ev, input int erd, input int ern, input int ed1,
                        input ctrl_t ec, input int ecnt, input int ed);
        exp_t x;
        @(posedge clk);
        #1;
        reset     = 1'(rst);
        id_valid  = 1'(v);
        id_rn     = 5'(rn);
        id_rm     = 5'(rm);
        id_rd     = 5'(rd);
        id_rdata1 = 64'(d1);
        id_rdata2 = 64'(d1) << 4;
        id_imm    = 64'(d1) * 64'd3;
        id_ctrl   = c;
        flush     = 1'(fl);
        mem_hold  = 1'(mh);
        x.stall = 1'(es);
        x.valid = 1'(ev);
        x.data  = 1'(ed);
        x.rd    = 5'(erd);
        x.rn    = 5'(ern);
        x.d1    = 64'(ed1);
        x.ctrl  = ec;
        x.cnt   = 16'(ecnt);
        sb.push_back(x);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall_id", 64'(stall_id), 64'(e.stall));
                chk("ex_valid", 64'(ex_valid), 64'(e.valid));
                chk("ex_rd", 64'(ex_rd), 64'(e.rd));
                chk("ex_ctrl", 64'(ex_ctrl), 64'(e.ctrl));
                chk("bubble_count", 64'(bubble_count), 64'(e.cnt));
                if (e.data) begin
                    chk("ex_rn", 64'(ex_rn), 64'(e.rn));
                    chk("ex_rdata1", ex_rdata1, e.d1);
                    chk("ex_rdata2", ex_rdata2, e.d1 << 4);
                    chk("ex_imm", ex_imm, e.d1 * 64'd3);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; id_valid = 1'b0; id_rn = '0; id_rm = '0; id_rd = '0;
        id_rdata1 = '0; id_rdata2 = '0; id_imm = '0; id_ctrl = Z; flush = 1'b0; mem_hold = 1'b0;
        //   rst v rn rm rd d1      ctrl fl mh | stall v rd rn d1      ctrl cnt     data
        step(1, 0, 0, 0, 0, 0,      Z,   0, 0,   0, 0, 31, 31, 0,      Z,   0,      1);
        step(0, 1, 3, 4, 7, 'h1234, ADD, 0, 0,   0, 0, 31, 31, 0,      Z,   0,      1);
        step(0, 1, 1, 0, 5, 'hAAAA, LD,  0, 0,   0, 1, 7,  3,  'h1234, ADD, 0,      1);
        step(0, 1, 5, 2, 6, 'h5555, ADD, 0, 0,   1, 1, 5,  1,  'hAAAA, LD,  0,      1);
        step(0, 1, 5, 2, 6, 'h5555, ADD, 0, 0,   0, 0, 31, 0,  0,      Z,   1,      0);
        step(0, 0, 0, 0, 0, 0,      Z,   0, 0,   0, 1, 6,  5,  'h5555, ADD, 1,      1);
        step(0, 1, 2, 0, 31, 1,     LD,  0, 0,   0, 0, 0,  0,  0,      Z,   1,      1);
        step(0, 1, 31, 31, 8, 2,    ADD, 0, 0,   0, 1, 31, 2,  1,      LD,  1,      1);
        step(0, 1, 3, 0, 9, 3,      LD,  0, 0,   0, 1, 8,  31, 2,      ADD, 1,      1);
        step(0, 1, 9, 0, 10, 4,     ADD, 1, 0,   0, 1, 9,  3,  3,      LD,  1,      1);
        step(0, 0, 0, 0, 0, 0,      Z,   0, 0,   0, 0, 31, 0,  0,      Z,   1,      0);
        step(0, 1, 4, 0, 12, 6,     LD,  0, 0,   0, 0, 0,  0,  0,      Z,   1,      1);
        step(0, 1, 1, 12, 13, 7,    ADD, 0, 1,   1, 1, 12, 4,  6,      LD,  1,      1);
        step(0, 1, 1, 12, 13, 7,    ADD, 0, 1,   1, 1, 12, 4,  6,      LD,  1,      1);
        step(0, 1, 1, 12, 13, 7,    ADD, 0, 1,   1, 1, 12, 4,  6,      LD,  1,      1);
        step(0, 1, 1, 12, 13, 7,    ADD, 0, 0,   1, 1, 12, 4,  6,      LD,  1,      1);
        step(0, 1, 1, 12, 13, 7,    ADD, 0, 0,   0, 0, 31, 0,  0,      Z,   2,      0);
        step(0, 0, 0, 0, 0, 0,      Z,   0, 0,   0, 1, 13, 1,  7,      ADD, 2,      1);
        step(0, 1, 0, 0, 14, 8,     LD,  0, 0,   0, 0, 0,  0,  0,      Z,   2,      1);
        step(0, 1, 2, 14, 15, 9,    LD,  0, 0,   0, 1, 14, 0,  8,      LD,  2,      1);
        step(0, 0, 0, 0, 0, 0,      Z,   0, 0,   0, 1, 15, 2,  9,      LD,  2,      1);
        // Preload the counter near saturation instead of replaying 65534 hazards.
        @(negedge clk);
        #1 force dut.bubble_q = 16'hFFFE;
        #2 release dut.bubble_q;
        step(0, 1, 0, 0, 5, 0,      LD,  0, 0,   0, 0, 0,  0,  0,      Z,   'hFFFE, 1);
        step(0, 1, 5, 0, 6, 1,      ADD, 0, 0,   1, 1, 5,  0,  0,      LD,  'hFFFE, 1);
        step(0, 1, 5, 0, 6, 1,      ADD, 0, 0,   0, 0, 31, 0,  0,      Z,   'hFFFF, 0);
        step(0, 1, 6, 0, 5, 3,      LD,  0, 0,   0, 1, 6,  5,  1,      ADD, 'hFFFF, 1);
        step(0, 1, 5, 0, 7, 4,      ADD, 0, 0,   1, 1, 5,  6,  3,      LD,  'hFFFF, 1);
        step(0, 1, 1, 0, 5, 5,      LD,  0, 0,   0, 0, 31, 0,  0,      Z,   'hFFFF, 0);
        step(1, 1, 5, 0, 8, 6,      ADD, 0, 0,   0, 1, 5,  1,  5,      LD,  'hFFFF, 1);
        step(0, 0, 0, 0, 0, 0,      Z,   0, 0,   0, 0, 31, 31, 0,      Z,   0,      1);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
